prog_imem: RTL and testbench

Parametrised, UART-loadable instruction memory that replaces the fixed 128-word ROM-style store. It takes a raw byte stream from the UART receiver, assembles little-endian 32-bit words, writes them sequentially from word 0, and stalls the core while loading. The core reads through an asynchronous port that returns NOP for any out-of-range fetch.

---
 rtl/imem_pkg.sv | 13 +
 rtl/prog_imem_word_assembler.sv | 51 +++++
 rtl/prog_imem.sv | 146 ++++++++++++++
 tb/tb_prog_imem.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared definitions for the UART-loadable instruction memory.
package imem_pkg;

  localparam int unsigned IMEM_DEPTH = 256;
  localparam logic [31:0] IMEM_NOP   = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    FINISH = 2'd2
  } imem_state_e;

endpackage

// File: rtl/prog_imem_word_assembler.sv
// Packs a little-endian byte stream into 32-bit words.
module word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word,
  output logic [1:0]  byte_idx
);

  logic [1:0]  idx_q, idx_d;
  logic [23:0] buf_q, buf_d;

  // Next byte slot and holding buffer; clr drops any partial word.
  always_comb begin
    idx_d = idx_q;
    buf_d = buf_q;
    if (clr) begin
      idx_d = '0;
    end else if (byte_valid) begin
      case (idx_q)
        2'd0:    buf_d[7:0]   = byte_data;
        2'd1:    buf_d[15:8]  = byte_data;
        2'd2:    buf_d[23:16] = byte_data;
        default: ;
      endcase
      idx_d = idx_q + 2'd1;
    end
  end

  // Byte index and buffer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
      buf_q <= '0;
    end else begin
      idx_q <= idx_d;
      buf_q <= buf_d;
    end
  end

  // The 4th byte completes the word combinationally so it is written on the same edge.
  always_comb begin
    word_valid = byte_valid && !clr && (idx_q == 2'd3);
    word       = {byte_data, buf_q};
    byte_idx   = idx_q;
  end

endmodule

// File: rtl/prog_imem.sv
// UART-loadable instruction memory with asynchronous NOP-guarded read port.
module prog_imem
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH = IMEM_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH),
  parameter logic [31:0] NOP   = IMEM_NOP
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [31:0]   A,
  output logic [31:0]   RD,
  input  logic          prog_en,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  output logic          core_stall,
  output logic          load_done,
  output logic [AW:0]   word_cnt,
  output logic [7:0]    checksum,
  output logic          ovf,
  output logic          frag
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  imem_state_e state_q, state_d;
  logic [AW:0] word_cnt_q, word_cnt_d;
  logic [7:0]  checksum_q, checksum_d;
  logic        ovf_q, ovf_d;
  logic        frag_q, frag_d;
  logic        load_done_q, load_done_d;

  logic        entry, accept, asm_clr, word_valid, wr_en, in_range;
  logic [31:0] asm_word;
  logic [1:0]  byte_idx;
  logic        addr_lsb_unused;

  logic [31:0] mem_q [DEPTH] = '{default: NOP};

  // Session control: bytes count only in LOAD while prog_en is still high.
  always_comb begin
    entry   = (state_q == IDLE) && prog_en;
    accept  = (state_q == LOAD) && prog_en && rx_valid;
    asm_clr = entry || (state_q == FINISH);
  end

  word_assembler u_asm (
    .clk        (CLK),
    .rst        (RST),
    .clr        (asm_clr),
    .byte_valid (accept),
    .byte_data  (rx_data),
    .word_valid (word_valid),
    .word       (asm_word),
    .byte_idx   (byte_idx)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (prog_en)  state_d = LOAD;
      LOAD:    if (!prog_en) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    core_stall = (state_q != IDLE);
  end

  // Session counters, sticky flags and end-of-session pulse.
  always_comb begin
    word_cnt_d  = word_cnt_q;
    checksum_d  = checksum_q;
    ovf_d       = ovf_q;
    frag_d      = frag_q;
    load_done_d = 1'b0;
    wr_en       = 1'b0;
    if (entry) begin
      word_cnt_d = '0;
      checksum_d = '0;
      ovf_d      = 1'b0;
      frag_d     = 1'b0;
    end
    if (accept) begin
      checksum_d = checksum_q + rx_data;
      if (word_valid) begin
        if (word_cnt_q == FULL_CNT) begin
          ovf_d = 1'b1;
        end else begin
          word_cnt_d = word_cnt_q + 1'b1;
          wr_en      = !RST;
        end
      end
    end
    if (state_q == FINISH) begin
      if (byte_idx != 2'd0) frag_d      = 1'b1;
      else                  load_done_d = 1'b1;
    end
  end

  // Counter and flag registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      word_cnt_q  <= '0;
      checksum_q  <= '0;
      ovf_q       <= 1'b0;
      frag_q      <= 1'b0;
      load_done_q <= 1'b0;
    end else begin
      word_cnt_q  <= word_cnt_d;
      checksum_q  <= checksum_d;
      ovf_q       <= ovf_d;
      frag_q      <= frag_d;
      load_done_q <= load_done_d;
    end
  end

  // Sequential word write; contents survive RST.
  always_ff @(posedge CLK) begin
    if (wr_en) mem_q[word_cnt_q[AW-1:0]] <= asm_word;
  end

  // Asynchronous read; the byte offset within a word is deliberately ignored.
  always_comb begin
    addr_lsb_unused = ^A[1:0];
    in_range        = (A[31:2] < 30'(DEPTH));
    RD              = in_range ? mem_q[A[AW+1:2]] : NOP;
  end

  assign load_done = load_done_q;
  assign word_cnt  = word_cnt_q;
  assign checksum  = checksum_q;
  assign ovf       = ovf_q;
  assign frag      = frag_q;

endmodule

// File: tb/tb_prog_imem.sv
// Directed bench for prog_imem (DEPTH = 256).
module tb_prog_imem;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int DEPTH = 256;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] A;
  logic [31:0] RD;
  logic        prog_en, rx_valid;
  logic [7:0]  rx_data;
  logic        core_stall, load_done, ovf, frag;
  logic [8:0]  word_cnt;
  logic [7:0]  checksum;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] exp;
  } rd_vec_t;

  rd_vec_t rv_reset [5];
  rd_vec_t rv_load  [6];

  prog_imem #(.DEPTH(DEPTH)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .A          (A),
    .RD         (RD),
    .prog_en    (prog_en),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .core_stall (core_stall),
    .load_done  (load_done),
    .word_cnt   (word_cnt),
    .checksum   (checksum),
    .ovf        (ovf),
    .frag       (frag)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_rd(input string nm, input logic [31:0] addr, input logic [31:0] exp);
    A = addr;
    #1;
    check(nm, RD, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  function automatic logic [7:0] ovf_byte(input int i);
    logic [31:0] v;
    v = i;
    return v[7:0] ^ v[15:8];
  endfunction

  initial begin
    logic [7:0] sum;

    rv_reset[0] = '{32'h0000_0000, NOP};
    rv_reset[1] = '{32'h0000_0004, NOP};
    rv_reset[2] = '{32'h0000_03FC, NOP};
    rv_reset[3] = '{32'h0000_0400, NOP};
    rv_reset[4] = '{32'hFFFF_FFFC, NOP};

    rv_load[0] = '{32'h0000_0000, 32'h0010_0093};
    rv_load[1] = '{32'h0000_0003, 32'h0010_0093};
    rv_load[2] = '{32'h0000_0004, 32'h8000_0337};
    rv_load[3] = '{32'h0000_0008, NOP};
    rv_load[4] = '{32'h0000_0400, NOP};
    rv_load[5] = '{32'h0000_0401, NOP};

    RST = 1'b1; A = '0; prog_en = 1'b0; rx_valid = 1'b0; rx_data = '0;
    tick(); tick();
    RST = 1'b0;
    tick();

    // Reset state and NOP reads
    check("rst_stall", core_stall, 0);
    check("rst_done", load_done, 0);
    check("rst_wcnt", word_cnt, 0);
    check("rst_csum", checksum, 0);
    check("rst_ovf", ovf, 0);
    check("rst_frag", frag, 0);
    for (int i = 0; i < 5; i++)
      check_rd($sformatf("rst_rd%0d", i), rv_reset[i].a, rv_reset[i].exp);

    // Session 1: strobe on the rising prog_en cycle must be dropped
    prog_en = 1'b1; rx_valid = 1'b1; rx_data = 8'hAA;
    tick();
    rx_valid = 1'b0;
    check("s1_stall_entry", core_stall, 1);
    send_byte(8'h93); send_byte(8'h00); send_byte(8'h10);
    // Same-cycle read sees old data, new word visible after the edge
    A = 32'h0; rx_valid = 1'b1; rx_data = 8'h00;
    #1;
    check("s1_rd_before_wr", RD, NOP);
    tick();
    rx_valid = 1'b0;
    check("s1_rd_after_wr", RD, 32'h0010_0093);
    send_byte(8'h37); send_byte(8'h03); send_byte(8'h00); send_byte(8'h80);
    // Strobe on the falling cycle must be dropped
    prog_en = 1'b0; rx_valid = 1'b1; rx_data = 8'h55;
    tick();
    rx_valid = 1'b0;
    check("s1_stall_finish", core_stall, 1);
    check("s1_done_early", load_done, 0);
    tick();
    check("s1_done", load_done, 1);
    check("s1_stall_idle", core_stall, 0);
    check("s1_wcnt", word_cnt, 2);
    check("s1_csum", checksum, 8'h5D);
    check("s1_frag", frag, 0);
    tick();
    check("s1_done_once", load_done, 0);
    for (int i = 0; i < 6; i++)
      check_rd($sformatf("s1_rd%0d", i), rv_load[i].a, rv_load[i].exp);

    // Session 2: 6 bytes leaves a fragment
    prog_en = 1'b1; tick();
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    send_byte(8'h44); send_byte(8'h55); send_byte(8'h66);
    prog_en = 1'b0; tick();
    tick();
    check("s2_frag", frag, 1);
    check("s2_done", load_done, 0);
    check("s2_wcnt", word_cnt, 1);
    check("s2_csum", checksum, 8'h65);
    check_rd("s2_rd0", 32'h0, 32'h4433_2211);
    check_rd("s2_rd1", 32'h4, 32'h8000_0337);
    tick();
    check("s2_frag_sticky", frag, 1);

    // Session 3: reset after 2 bytes of word 3
    prog_en = 1'b1; tick();
    check("s3_frag_clr", frag, 0);
    send_byte(8'h04); send_byte(8'h03); send_byte(8'h02); send_byte(8'h01);
    send_byte(8'h08); send_byte(8'h07); send_byte(8'h06); send_byte(8'h05);
    send_byte(8'h0C); send_byte(8'h0B); send_byte(8'h0A); send_byte(8'h09);
    send_byte(8'hEE); send_byte(8'hFF);
    RST = 1'b1; prog_en = 1'b0; tick();
    RST = 1'b0;
    check("s3_stall", core_stall, 0);
    check("s3_wcnt", word_cnt, 0);
    check("s3_csum", checksum, 0);
    check("s3_frag", frag, 0);
    check("s3_done", load_done, 0);
    tick(); tick();
    check("s3_done_after", load_done, 0);
    check("s3_frag_after", frag, 0);
    check_rd("s3_rd0", 32'h0, 32'h0102_0304);
    check_rd("s3_rd1", 32'h4, 32'h0506_0708);
    check_rd("s3_rd2", 32'h8, 32'h090A_0B0C);
    check_rd("s3_rd3", 32'hC, NOP);

    // Session 4: fill the memory, then one extra word overflows
    prog_en = 1'b1; tick();
    sum = '0;
    for (int i = 0; i < 4*DEPTH; i++) begin
      sum += ovf_byte(i);
      send_byte(ovf_byte(i));
    end
    check("s4_wcnt_full", word_cnt, DEPTH);
    check("s4_ovf_pre", ovf, 0);
    for (int i = 4*DEPTH; i < 4*DEPTH+4; i++) begin
      sum += ovf_byte(i);
      send_byte(ovf_byte(i));
    end
    check("s4_wcnt_sat", word_cnt, DEPTH);
    check("s4_ovf", ovf, 1);
    check("s4_csum", checksum, sum);
    prog_en = 1'b0; tick(); tick();
    check("s4_done", load_done, 1);
    check("s4_ovf_sticky", ovf, 1);
    check_rd("s4_rd0", 32'h0, 32'h0302_0100);
    check_rd("s4_rd255", 32'h3FC, 32'hFCFD_FEFF);
    check_rd("s4_rd_oob", 32'h400, NOP);

    // New session entry clears sticky state
    prog_en = 1'b1; tick();
    check("s5_ovf_clr", ovf, 0);
    check("s5_wcnt_clr", word_cnt, 0);
    check("s5_csum_clr", checksum, 0);
    prog_en = 1'b0; tick(); tick();
    check("s5_done", load_done, 1);
    check_rd("s5_rd0_kept", 32'h0, 32'h0302_0100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
